pool_window_gen: RTL and testbench

- Stride-2, non-overlapping 2x2 window generator that feeds the max-pool stage.
- Accepts a raster-order pixel stream, one pixel per handshake.
- Buffers one even row, then emits four-pixel windows on data0..data3 with data_valid/data_ready, matching the pool's input side.
- Sits between the conv/feature-map output stream and the pool stage.

---
 rtl/pool_pkg.sv | 20 ++
 rtl/pool_linebuf.sv | 31 +++
 rtl/pool_window_gen.sv | 138 +++++++++++++
 tb/tb_pool_window_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared row-state enum, default geometry and window index order for the pool path
package pool_pkg;

  // Even image rows fill the line buffer, odd rows complete windows
  typedef enum logic {
    TOP = 1'b0,
    BOT = 1'b1
  } row_state_t;

  localparam int POOL_DW    = 8;
  localparam int POOL_IMG_W = 8;
  localparam int POOL_IMG_H = 8;

  // Slot order of the four window pixels, shared with the pool stage
  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

endpackage

// File: rtl/pool_linebuf.sv
// rtl/pool_linebuf.sv - one-row pixel store with one write port and two combinational read ports
module pool_linebuf
  import pool_pkg::*;
#(
  parameter int IMG_W = POOL_IMG_W,
  parameter int DW    = POOL_DW,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [IMG_W];

  // Contents are deliberately not reset; a location is always written before it is read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window_gen.sv
// rtl/pool_window_gen.sv - stride-2 2x2 window generator; WINGEN_FRAME_DONE_EN adds a frame_done pulse
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int IMG_W = POOL_IMG_W,
  parameter int IMG_H = POOL_IMG_H,
  parameter int DW    = POOL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [DW-1:0] data0,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  output logic [DW-1:0] data3,
  output logic          data_valid,
  input  logic          data_ready
`ifdef WINGEN_FRAME_DONE_EN
  ,
  output logic          frame_done
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  row_state_t    row_st;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] pend_left;
  logic [DW-1:0] win_q [4];
  logic          win_valid;

  logic          completing;
  logic          accept;
  logic          capture;
  logic          out_fire;
  logic          col_end;
  logic          lb_we;
  logic [CW-1:0] col_left;
  logic [DW-1:0] lb_left;
  logic [DW-1:0] lb_right;

  // Only the window-completing pixel must wait for the output register to drain
  assign completing = (row_st == BOT) && col[0];
  assign pix_ready  = !(win_valid && !data_ready && completing);
  assign accept     = pix_valid && pix_ready;
  assign capture    = accept && completing;
  assign out_fire   = win_valid && data_ready;
  assign col_end    = (col == COL_LAST);
  assign lb_we      = accept && (row_st == TOP);
  assign col_left   = col - CW'(1);

  pool_linebuf #(
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_linebuf (
    .clk     (clk),
    .we      (lb_we),
    .waddr   (col),
    .wdata   (pix_data),
    .raddr_a (col_left),
    .rdata_a (lb_left),
    .raddr_b (col),
    .rdata_b (lb_right)
  );

  // Column/row counters and the TOP/BOT row state machine; frozen while no pixel is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      row_st    <= TOP;
      pend_left <= '0;
    end else if (accept) begin
      if ((row_st == BOT) && !col[0]) begin
        pend_left <= pix_data;
      end
      if (col_end) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        case (row_st)
          TOP:     row_st <= BOT;
          BOT:     row_st <= TOP;
          default: row_st <= TOP;
        endcase
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Output register: a new capture wins over the drain, giving one window per cycle at peak
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        win_q[i] <= '0;
      end
      win_valid <= 1'b0;
    end else if (capture) begin
      win_q[WIN_TL] <= lb_left;
      win_q[WIN_TR] <= lb_right;
      win_q[WIN_BL] <= pend_left;
      win_q[WIN_BR] <= pix_data;
      win_valid     <= 1'b1;
    end else if (out_fire) begin
      win_valid <= 1'b0;
    end
  end

  assign data0      = win_q[WIN_TL];
  assign data1      = win_q[WIN_TR];
  assign data2      = win_q[WIN_BL];
  assign data3      = win_q[WIN_BR];
  assign data_valid = win_valid;

`ifdef WINGEN_FRAME_DONE_EN
  logic win_last;

  // Remember whether the held window closes the frame, and pulse once it has been taken
  always_ff @(posedge clk) begin
    if (rst) begin
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (capture) begin
        win_last <= (row == ROW_LAST) && col_end;
      end
      frame_done <= out_fire && win_last;
    end
  end
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// tb/tb_pool_window_gen.sv - directed and random bench for a 4x4 and an 8x8 pool_window_gen
module tb_pool_window_gen;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst [2] = '{1'b1, 1'b1};
  logic [DW-1:0] pix_data [2] = '{8'd0, 8'd0};
  logic          pix_valid [2] = '{1'b0, 1'b0};
  logic          pix_ready [2];
  logic [DW-1:0] dout [2][4];
  logic          data_valid [2];
  logic          data_ready [2] = '{1'b0, 1'b0};
`ifdef WINGEN_FRAME_DONE_EN
  logic          frame_done [2];
  bit            fd_exp [2] = '{1'b0, 1'b0};
  int            fd_cnt [2] = '{0, 0};
  bit            ring_last [2][8];
`endif

  int            n_cmp = 0;
  int            n_bad = 0;

  // Behavioural model state: frame image by raster position, queue of pending windows, consumed log
  int            pos [2] = '{0, 0};
  logic [DW-1:0] img [2][64];
  logic [31:0]   ring [2][8];
  int            wr [2] = '{0, 0};
  int            rd [2] = '{0, 0};
  logic [31:0]   logw [2][64];
  int            log_n [2] = '{0, 0};
  bit            rand_done = 1'b0;

  always #5 clk = ~clk;

  pool_window_gen #(.IMG_W(4), .IMG_H(4), .DW(DW)) u_dut4 (
    .clk        (clk),
    .rst        (rst[0]),
    .pix_data   (pix_data[0]),
    .pix_valid  (pix_valid[0]),
    .pix_ready  (pix_ready[0]),
    .data0      (dout[0][0]),
    .data1      (dout[0][1]),
    .data2      (dout[0][2]),
    .data3      (dout[0][3]),
    .data_valid (data_valid[0]),
    .data_ready (data_ready[0])
`ifdef WINGEN_FRAME_DONE_EN
    ,
    .frame_done (frame_done[0])
`endif
  );

  pool_window_gen #(.IMG_W(8), .IMG_H(8), .DW(DW)) u_dut8 (
    .clk        (clk),
    .rst        (rst[1]),
    .pix_data   (pix_data[1]),
    .pix_valid  (pix_valid[1]),
    .pix_ready  (pix_ready[1]),
    .data0      (dout[1][0]),
    .data1      (dout[1][1]),
    .data2      (dout[1][2]),
    .data3      (dout[1][3]),
    .data_valid (data_valid[1]),
    .data_ready (data_ready[1])
`ifdef WINGEN_FRAME_DONE_EN
    ,
    .frame_done (frame_done[1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    pix_data[i]  = v;
    pix_valid[i] = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (pix_ready[i]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    pix_valid[i] = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout u%0d: pixel %0d not accepted, required within 100 cycles", i, v);
    end
  endtask

  // Compare process: model derives every expected output from raster position and queued windows
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int          w;
        int          r;
        int          c;
        bit          have;
        bit          comp;
        bit          exp_pr;
        logic [31:0] act;
        w = (i == 0) ? 4 : 8;
        if (rst[i]) begin
          pos[i] = 0;
          rd[i]  = wr[i];
`ifdef WINGEN_FRAME_DONE_EN
          fd_exp[i] = 1'b0;
`endif
          continue;
        end
        r      = pos[i] / w;
        c      = pos[i] % w;
        have   = (wr[i] != rd[i]);
        comp   = (r % 2 == 1) && (c % 2 == 1);
        exp_pr = !(have && !data_ready[i] && comp);
        act    = {dout[i][0], dout[i][1], dout[i][2], dout[i][3]};
        chk($sformatf("u%0d data_valid", i), {63'd0, data_valid[i]}, {63'd0, have});
        chk($sformatf("u%0d pix_ready", i), {63'd0, pix_ready[i]}, {63'd0, exp_pr});
        if (have) chk($sformatf("u%0d window", i), {32'd0, act}, {32'd0, ring[i][rd[i] % 8]});
`ifdef WINGEN_FRAME_DONE_EN
        chk($sformatf("u%0d frame_done", i), {63'd0, frame_done[i]}, {63'd0, fd_exp[i]});
        if (frame_done[i] === 1'b1) fd_cnt[i]++;
        fd_exp[i] = 1'b0;
`endif
        if (have && data_ready[i]) begin
          if (log_n[i] < 64) logw[i][log_n[i]] = act;
          log_n[i]++;
`ifdef WINGEN_FRAME_DONE_EN
          fd_exp[i] = ring_last[i][rd[i] % 8];
`endif
          rd[i]++;
        end
        if (pix_valid[i] && exp_pr) begin
          img[i][pos[i]] = pix_data[i];
          if (comp) begin
            ring[i][wr[i] % 8] = {img[i][pos[i]-w-1], img[i][pos[i]-w], img[i][pos[i]-1], pix_data[i]};
`ifdef WINGEN_FRAME_DONE_EN
            ring_last[i][wr[i] % 8] = (pos[i] == w * w - 1);
`endif
            wr[i]++;
          end
          pos[i] = (pos[i] + 1) % (w * w);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
`ifdef WINGEN_FRAME_DONE_EN
    int fd_base;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset u%0d data_valid", i), {63'd0, data_valid[i]}, 64'd0);
      chk($sformatf("reset u%0d pix_ready", i), {63'd0, pix_ready[i]}, 64'd1);
      chk($sformatf("reset u%0d data", i),
          {32'd0, dout[i][0], dout[i][1], dout[i][2], dout[i][3]}, 64'd0);
    end

    // 4x4 frame with consumer always ready: fixed windows and 1-cycle latency
    data_ready[0] = 1'b1;
    base = log_n[0];
    for (int k = 0; k < 16; k++) begin
      push(0, 8'(k));
      chk($sformatf("t1 data_valid after pixel %0d", k), {63'd0, data_valid[0]},
          {63'd0, (k == 5 || k == 7 || k == 13 || k == 15)});
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t1 window count", 64'(log_n[0] - base), 64'd4);
    chk("t1 win0", {32'd0, logw[0][base]},   64'h00010405);
    chk("t1 win1", {32'd0, logw[0][base+1]}, 64'h02030607);
    chk("t1 win2", {32'd0, logw[0][base+2]}, 64'h08090c0d);
    chk("t1 win3", {32'd0, logw[0][base+3]}, 64'h0a0b0e0f);

    // Consumer stalled for 6 cycles after the first window
    data_ready[0] = 1'b0;
    base = log_n[0];
    for (int k = 0; k < 6; k++) push(0, 8'(k));
    fork
      begin
        repeat (6) @(posedge clk);
        #1;
        data_ready[0] = 1'b1;
      end
    join_none
    pix_data[0]  = 8'd6;
    pix_valid[0] = 1'b1;
    @(negedge clk);
    chk("t2 pix_ready for pixel 6", {63'd0, pix_ready[0]}, 64'd1);
    @(posedge clk);
    #1;
    pix_data[0] = 8'd7;
    @(negedge clk);
    chk("t2 pix_ready for pixel 7", {63'd0, pix_ready[0]}, 64'd0);
    chk("t2 held window", {32'd0, dout[0][0], dout[0][1], dout[0][2], dout[0][3]}, 64'h00010405);
    push(0, 8'd7);
    chk("t2 back-to-back valid", {63'd0, data_valid[0]}, 64'd1);
    chk("t2 second window", {32'd0, dout[0][0], dout[0][1], dout[0][2], dout[0][3]}, 64'h02030607);
    for (int k = 8; k < 16; k++) push(0, 8'(k));
    repeat (3) @(posedge clk);
    #1;
    chk("t2 window count", 64'(log_n[0] - base), 64'd4);

    // Two back-to-back frames without gaps
    base = log_n[0];
`ifdef WINGEN_FRAME_DONE_EN
    fd_base = fd_cnt[0];
`endif
    for (int k = 0; k < 16; k++) push(0, 8'(k));
    for (int k = 0; k < 16; k++) push(0, 8'(100 + k));
    repeat (4) @(posedge clk);
    #1;
    chk("t3 window count", 64'(log_n[0] - base), 64'd8);
    chk("t3 fifth window", {32'd0, logw[0][base+4]}, 64'h64656869);
`ifdef WINGEN_FRAME_DONE_EN
    chk("t3 frame_done pulses", 64'(fd_cnt[0] - fd_base), 64'd2);
`endif

    // Reset in the middle of a frame
    for (int k = 0; k < 10; k++) push(0, 8'(k));
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    chk("t4 valid after reset", {63'd0, data_valid[0]}, 64'd0);
    base = log_n[0];
    for (int k = 0; k < 16; k++) push(0, 8'(50 + k));
    repeat (3) @(posedge clk);
    #1;
    chk("t4 window count", 64'(log_n[0] - base), 64'd4);
    chk("t4 first window", {32'd0, logw[0][base]}, 64'h32333637);

    // Random valid/ready on the 8x8 instance, three frames
    base = log_n[1];
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          data_ready[1] = 1'($urandom % 2);
        end
      end
      begin
        for (int k = 0; k < 192; k++) begin
          repeat ($urandom % 2) begin
            @(posedge clk);
            #1;
          end
          push(1, 8'($urandom));
        end
        rand_done = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    data_ready[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6 random window count", 64'(log_n[1] - base), 64'd48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
